// File: rtl/gru_sequence_ctrl_if.sv
// Handshake bundle for gru_sequence_ctrl: x stream in, gruCell recurrent loop,
// final hidden-state stream out, plus status.
interface gru_sequence_ctrl_if #(
   parameter int WIDTH  = 16,
   parameter int x_SIZE = 8,
   parameter int h_SIZE = 8,
   parameter int STEP_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_first;
   logic                    in_last;
   logic signed [WIDTH-1:0] in_x        [0:x_SIZE-1];
   logic signed [WIDTH-1:0] cell_x_t    [0:x_SIZE-1];
   logic signed [WIDTH-1:0] cell_h_prev [0:h_SIZE-1];
   logic signed [WIDTH-1:0] cell_h_t    [0:h_SIZE-1];
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_h       [0:h_SIZE-1];
   logic [STEP_W-1:0]       step_count;
   logic                    busy;

   modport master (
      output in_valid, in_first, in_last, in_x,
      output cell_h_t, out_ready,
      input  in_ready, cell_x_t, cell_h_prev,
      input  out_valid, out_h, step_count, busy
   );

   modport slave (
      input  in_valid, in_first, in_last, in_x,
      input  cell_h_t, out_ready,
      output in_ready, cell_x_t, cell_h_prev,
      output out_valid, out_h, step_count, busy
   );
endinterface

// File: rtl/gru_sequence_ctrl.sv
// Sequences x_t vectors through a fixed-latency gruCell and feeds h_t back
// as h_t_minus_1; the final hidden state leaves on a valid/ready stream.
module gru_sequence_ctrl #(
   parameter int WIDTH        = 16,
   parameter int NFRAC        = 12,
   parameter int x_SIZE       = 8,
   parameter int h_SIZE       = 8,
   parameter int CELL_LATENCY = 3,
   parameter int STEP_W       = 8
) (
   input logic          clk,
   input logic          reset,
   gru_sequence_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(CELL_LATENCY + 1);

   if (CELL_LATENCY < 1 || NFRAC < 0 || NFRAC >= WIDTH) begin : g_bad_param
      $error("gru_sequence_ctrl: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, WAIT, OUT} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    last_q, last_d;
   logic [STEP_W-1:0]       step_q, step_d;
   logic                    load_x, clear_h, capture_h;
   logic signed [WIDTH-1:0] x_q [0:x_SIZE-1];
   logic signed [WIDTH-1:0] h_q [0:h_SIZE-1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      step_d    = step_q;
      load_x    = 1'b0;
      clear_h   = 1'b0;
      capture_h = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               load_x  = 1'b1;
               last_d  = bus.in_last;
               cnt_d   = CNT_W'(CELL_LATENCY);
               state_d = WAIT;
               if (bus.in_first) begin
                  clear_h = 1'b1;
                  step_d  = '0;
               end
            end
         end
         WAIT: begin
            // cell output is only trusted on the last edge of the window
            if (cnt_q == CNT_W'(1)) begin
               capture_h = 1'b1;
               if (step_q != '1) step_d = step_q + 1'b1;
               state_d = last_q ? OUT : IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         OUT: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         step_q  <= step_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_q <= '{default: '0};
         h_q <= '{default: '0};
      end else begin
         if (load_x) x_q <= bus.in_x;
         if (clear_h) h_q <= '{default: '0};
         else if (capture_h) h_q <= bus.cell_h_t;
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == OUT);
   assign bus.busy        = (state_q != IDLE);
   assign bus.step_count  = step_q;
   assign bus.cell_x_t    = x_q;
   assign bus.cell_h_prev = h_q;
   assign bus.out_h       = h_q;
endmodule

// File: tb/tb_gru_sequence_ctrl.sv
// Bench for gru_sequence_ctrl: stub cell h_t = x_t + h_prev behind a fixed
// latency, compared against a sequence-level running-sum model.
module tb_gru_sequence_ctrl;
   localparam int W   = 16;
   localparam int XS  = 8;
   localparam int HS  = 8;
   localparam int LAT = 3;
   localparam int SW  = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   gru_sequence_ctrl_if #(
      .WIDTH(W), .x_SIZE(XS), .h_SIZE(HS), .STEP_W(SW)
   ) bus ();

   gru_sequence_ctrl #(
      .WIDTH(W), .NFRAC(12), .x_SIZE(XS), .h_SIZE(HS),
      .CELL_LATENCY(LAT), .STEP_W(SW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // stub cell: sum is valid only LAT-1 edges after its inputs change,
   // so a capture on any earlier edge sees stale data
   logic [W-1:0] stage [LAT-1][HS];
   always @(posedge clk) begin
      for (int i = 0; i < HS; i++) begin
         stage[0][i] <= bus.cell_x_t[i] + bus.cell_h_prev[i];
         for (int k = 1; k < LAT - 1; k++) stage[k][i] <= stage[k-1][i];
      end
   end
   always_comb begin
      for (int i = 0; i < HS; i++) bus.cell_h_t[i] = stage[LAT-2][i];
   end

   int total = 0;
   int bad = 0;
   logic [W-1:0] stim_x [XS];
   logic [W-1:0] m_h [HS];
   int           m_steps = 0;
   int           len;

   task automatic chk(input string tag, input logic [W-1:0] got,
                      input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_x(input logic [W-1:0] v);
      for (int i = 0; i < XS; i++) stim_x[i] = v;
   endtask

   task automatic noise(input bit on);
      bus.in_valid = on ? 1'($urandom) : 1'b0;
      bus.in_first = 1'($urandom);
      bus.in_last  = 1'($urandom);
      for (int i = 0; i < XS; i++) bus.in_x[i] = W'($urandom);
   endtask

   // one timestep; hold<0 gives random out_ready backpressure
   task automatic do_step(input bit first, input bit last,
                          input int hold, input bit nz);
      logic [W-1:0] xs [XS];
      logic [W-1:0] hp [HS];
      int old_steps;
      int n;
      bit r;
      for (int i = 0; i < XS; i++) xs[i] = stim_x[i];
      chk("rdy_idle", W'(bus.in_ready), 1);
      chk("busy_idle", W'(bus.busy), 0);
      bus.in_valid = 1'b1;
      bus.in_first = first;
      bus.in_last  = last;
      for (int i = 0; i < XS; i++) bus.in_x[i] = xs[i];
      @(posedge clk); #1;
      if (first) begin
         for (int i = 0; i < HS; i++) m_h[i] = '0;
         m_steps = 0;
      end
      old_steps = m_steps;
      for (int i = 0; i < HS; i++) hp[i] = m_h[i];
      for (int i = 0; i < HS; i++) m_h[i] = m_h[i] + xs[i];
      if (m_steps < 2**SW - 1) m_steps++;
      for (int c = 0; c < LAT; c++) begin
         noise(nz);
         chk("rdy_wait", W'(bus.in_ready), 0);
         chk("busy_wait", W'(bus.busy), 1);
         chk("ov_wait", W'(bus.out_valid), 0);
         chk("step_wait", W'(bus.step_count), W'(old_steps));
         for (int i = 0; i < XS; i++) chk("x_hold", bus.cell_x_t[i], xs[i]);
         for (int i = 0; i < HS; i++) chk("hp_hold", bus.cell_h_prev[i], hp[i]);
         @(posedge clk); #1;
      end
      noise(1'b0);
      chk("step_cap", W'(bus.step_count), W'(m_steps));
      for (int i = 0; i < HS; i++) chk("h_cap", bus.cell_h_prev[i], m_h[i]);
      if (last) begin
         n = 0;
         do begin
            chk("ov_out", W'(bus.out_valid), 1);
            chk("rdy_out", W'(bus.in_ready), 0);
            chk("step_out", W'(bus.step_count), W'(m_steps));
            for (int i = 0; i < HS; i++) chk("out_h", bus.out_h[i], m_h[i]);
            if (hold < 0) bus.out_ready = 1'($urandom);
            else bus.out_ready = (n >= hold);
            if (n >= 10) bus.out_ready = 1'b1;
            r = bus.out_ready;
            noise(nz);
            @(posedge clk); #1;
            n++;
         end while (!r);
         bus.out_ready = 1'b0;
         noise(1'b0);
      end
      chk("ov_idle", W'(bus.out_valid), 0);
      chk("rdy_after", W'(bus.in_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.out_ready = 1'b0;
      noise(1'b0);
      for (int i = 0; i < HS; i++) m_h[i] = '0;
      #2;
      chk("rst_rdy", W'(bus.in_ready), 1);
      chk("rst_ov", W'(bus.out_valid), 0);
      chk("rst_busy", W'(bus.busy), 0);
      chk("rst_step", W'(bus.step_count), 0);
      for (int i = 0; i < HS; i++) begin
         chk("rst_x", bus.cell_x_t[i], 0);
         chk("rst_hp", bus.cell_h_prev[i], 0);
         chk("rst_outh", bus.out_h[i], 0);
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      set_x(16'h0100);
      do_step(1, 1, 0, 0);

      set_x(16'h0010); do_step(1, 0, 0, 0);
      set_x(16'h0020); do_step(0, 0, 0, 0);
      set_x(16'h0030); do_step(0, 1, 0, 0);
      chk("seq3_h", bus.out_h[0], 16'h0060);

      set_x(16'h0010); do_step(1, 0, 0, 0);
      set_x(16'h0020); do_step(0, 0, 0, 0);
      set_x(16'h0030); do_step(0, 1, 5, 0);

      set_x(16'h0010); do_step(1, 0, 0, 0);
      set_x(16'h0010); do_step(0, 0, 0, 0);
      set_x(16'h0005); do_step(1, 1, 0, 0);
      chk("restart_h", bus.out_h[3], 16'h0005);
      chk("restart_n", W'(bus.step_count), 1);

      set_x(16'h7FF0); do_step(1, 0, 0, 0);
      set_x(16'h0020); do_step(0, 1, 0, 0);
      chk("wrap_h", bus.out_h[7], 16'h8010);

      set_x(16'h0040);
      bus.in_valid = 1'b1;
      bus.in_first = 1'b1;
      bus.in_last  = 1'b0;
      for (int i = 0; i < XS; i++) bus.in_x[i] = stim_x[i];
      @(posedge clk); #1;
      noise(1'b0);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      chk("arst_rdy", W'(bus.in_ready), 1);
      chk("arst_busy", W'(bus.busy), 0);
      chk("arst_step", W'(bus.step_count), 0);
      chk("arst_hp", bus.cell_h_prev[0], 0);
      chk("arst_x", bus.cell_x_t[0], 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < HS; i++) m_h[i] = '0;
      m_steps = 0;
      @(posedge clk); #1;
      set_x(16'h0003); do_step(0, 0, 0, 0);
      set_x(16'h0004); do_step(0, 1, 0, 0);
      chk("post_rst_h", bus.out_h[1], 16'h0007);

      set_x(16'h0001);
      do_step(1, 0, 0, 0);
      for (int s = 0; s < 257; s++) do_step(0, 0, 0, 0);
      do_step(0, 1, 0, 0);
      chk("sat_n", W'(bus.step_count), 255);

      for (int q = 0; q < 30; q++) begin
         len = $urandom_range(1, 5);
         for (int s = 0; s < len; s++) begin
            for (int i = 0; i < XS; i++) stim_x[i] = W'($urandom);
            do_step(s == 0 ? ($urandom % 4 != 0) : ($urandom % 8 == 0),
                    s == len - 1, -1, 1'($urandom));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
